// File: rtl/enc_pkg.sv
// enc_pkg: shared encodings for the MIPS instruction encoder.
//   - kind_e      : 4-bit symbolic instruction kind presented on kind_i
//   - OP_* / FN_* : opcode and funct fields matching the CPU control decoder
//   - WORD_STRIDE : byte distance between consecutive instruction words
//   - NOP_WORD    : sll $0,$0,0, substituted for illegal kinds when checking is off
package enc_pkg;

   typedef enum logic [3:0] {
      KIND_ADD  = 4'd0,
      KIND_SUB  = 4'd1,
      KIND_AND  = 4'd2,
      KIND_OR   = 4'd3,
      KIND_SLT  = 4'd4,
      KIND_ADDI = 4'd5,
      KIND_ORI  = 4'd6,
      KIND_BEQ  = 4'd7
   } kind_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam int unsigned WORD_STRIDE = 4;
   localparam logic [31:0] NOP_WORD    = '0;

   // Kinds 8..15 are unassigned; the MSB alone separates them.
   function automatic logic kind_is_legal(input logic [3:0] kind);
      return !kind[3];
   endfunction

endpackage

// File: rtl/enc_pack.sv
// enc_pack: purely combinational field-to-word packer.
// Ports:
//   kind_i  [3:0]  instruction kind (see enc_pkg::kind_e)
//   rs_i, rt_i, rd_i [4:0]  register fields (rd_i ignored for I-type)
//   imm_i   [15:0] immediate / branch offset, passed through unmodified
//   word_o  [31:0] packed machine word (undefined content for illegal kinds)
//   legal_o        kind is one of the eight supported encodings
module enc_pack
   import enc_pkg::*;
(
   input  logic [3:0]  kind_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [15:0] imm_i,
   output logic [31:0] word_o,
   output logic        legal_o
);

   logic [5:0] funct;

   always_comb begin
      funct   = '0;
      legal_o = kind_is_legal(kind_i);
      case (kind_i)
         KIND_ADD: funct = FN_ADD;
         KIND_SUB: funct = FN_SUB;
         KIND_AND: funct = FN_AND;
         KIND_OR:  funct = FN_OR;
         KIND_SLT: funct = FN_SLT;
         default:  funct = '0;
      endcase

      word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, funct};
      case (kind_i)
         KIND_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
         KIND_ORI:  word_o = {OP_ORI,  rs_i, rt_i, imm_i};
         KIND_BEQ:  word_o = {OP_BEQ,  rs_i, rt_i, imm_i};
         default:   ;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS instruction encoder. Packs symbolic fields
// into 32-bit words and emits them through a one-entry valid/ready register,
// each tagged with an auto-incrementing byte address.
// Optional feature macro: ENC_CHECK_EN -- illegal kinds (8..15) are consumed
// without producing a word and set the sticky err_o flag. When undefined,
// illegal kinds are delivered as a NOP word and err_o is tied 0.
// Ports:
//   clk_i, rst_i (sync, active-low), start_i (reload address / clear count)
//   in_valid_i / in_ready_o     : field bundle handshake
//   kind_i, rs_i, rt_i, rd_i, imm_i : instruction fields
//   out_valid_o / out_ready_i   : word handshake
//   instr_o, addr_o, count_o    : word, its byte address, words delivered
//   err_o                       : sticky illegal-kind flag
module instr_encoder
   import enc_pkg::*;
#(
   parameter int unsigned         ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [3:0]        kind_i,
   input  logic [4:0]        rs_i,
   input  logic [4:0]        rt_i,
   input  logic [4:0]        rd_i,
   input  logic [15:0]       imm_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [15:0]       count_o,
   output logic              err_o
);

   logic [31:0]       word;
   logic [31:0]       load_word;
   logic              legal;
   logic              accept;
   logic              deliver;
   logic              load;

   logic              out_valid_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       count_q;

   enc_pack u_pack (
      .kind_i  (kind_i),
      .rs_i    (rs_i),
      .rt_i    (rt_i),
      .rd_i    (rd_i),
      .imm_i   (imm_i),
      .word_o  (word),
      .legal_o (legal)
   );

   assign deliver    = out_valid_q && out_ready_i;
   assign in_ready_o = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

`ifdef ENC_CHECK_EN
   logic err_q;

   // Illegal bundles complete their handshake but never reach the register.
   assign load      = accept && legal;
   assign load_word = word;

   // An illegal bundle accepted alongside start_i is newer than the start,
   // so it still raises the flag.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         err_q <= 1'b0;
      end else if (accept && !legal) begin
         err_q <= 1'b1;
      end else if (start_i) begin
         err_q <= 1'b0;
      end
   end

   assign err_o = err_q;
`else
   assign load      = accept;
   assign load_word = legal ? word : NOP_WORD;
   assign err_o     = 1'b0;
`endif

   // A load in the delivery cycle keeps valid high for the replacement word.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         out_valid_q <= 1'b0;
         instr_q     <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         instr_q     <= load_word;
      end else if (deliver) begin
         out_valid_q <= 1'b0;
      end
   end

   // start_i overrides the post-delivery increment; the delivered word has
   // already been reported with the old address.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         addr_q  <= BASE_ADDR;
         count_q <= '0;
      end else if (start_i) begin
         addr_q  <= BASE_ADDR;
         count_q <= '0;
      end else if (deliver) begin
         addr_q <= addr_q + ADDR_W'(WORD_STRIDE);
         if (count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign instr_o     = instr_q;
   assign addr_o      = addr_q;
   assign count_o     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model. A second instance with an
// 8-bit address starting at 0xFC shares the stimulus to exercise wrap-around.
module tb_instr_encoder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, start_i, in_valid_i, out_ready_i;
   logic [3:0]  kind_i;
   logic [4:0]  rs_i, rt_i, rd_i;
   logic [15:0] imm_i;

   logic        in_ready, out_valid, err;
   logic [31:0] instr, addr;
   logic [15:0] count;

   logic        in_ready8, out_valid8, err8;
   logic [31:0] instr8;
   logic [7:0]  addr8;
   logic [15:0] count8;

`ifdef ENC_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   instr_encoder dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready),
      .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .imm_i(imm_i),
      .out_valid_o(out_valid), .out_ready_i(out_ready_i),
      .instr_o(instr), .addr_o(addr), .count_o(count), .err_o(err)
   );

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'hFC)) dut8 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready8),
      .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .imm_i(imm_i),
      .out_valid_o(out_valid8), .out_ready_i(out_ready_i),
      .instr_o(instr8), .addr_o(addr8), .count_o(count8), .err_o(err8)
   );

   int unsigned n_compared   = 0;
   int unsigned n_mismatched = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: words waiting for delivery, last word loaded, and the
   // number of words delivered since the last reset/start.
   logic [31:0] pend[$];
   logic [31:0] last_word = '0;
   int unsigned sent      = 0;
   bit          err_m     = 1'b0;
   bit          model_ok  = 1'b0;

   function automatic logic [31:0] ref_encode(input logic [3:0] k, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [4:0] rd,
                                              input logic [15:0] imm);
      logic [5:0] fn_tbl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      if (k <= 4'd4) return {6'd0, rs, rt, rd, 5'd0, fn_tbl[k]};
      case (k)
         4'd5:    return {6'h08, rs, rt, imm};
         4'd6:    return {6'h0D, rs, rt, imm};
         4'd7:    return {6'h04, rs, rt, imm};
         default: return 32'h0;
      endcase
   endfunction

   // One clock: inputs were set at posedge+1; check at posedge+3, advance the
   // model by what the coming edge should do, then return at posedge+1.
   task automatic tick();
      bit rdy, hs, acc;
      logic [31:0] w;
      int unsigned cnt;
      #2;
      if (model_ok) begin
         rdy = (pend.size() == 0) || out_ready_i;
         cnt = (sent > 65535) ? 65535 : sent;
         check_eq("out_valid", out_valid, pend.size() != 0);
         check_eq("in_ready",  in_ready,  rdy);
         check_eq("instr",     instr,     last_word);
         check_eq("addr",      addr,      32'(sent * 4));
         check_eq("count",     count,     cnt);
         check_eq("err",       err,       err_m);
         check_eq("out_valid8", out_valid8, pend.size() != 0);
         check_eq("in_ready8",  in_ready8,  rdy);
         check_eq("instr8",     instr8,     last_word);
         check_eq("addr8",      addr8,      32'(8'(252 + sent * 4)));
         check_eq("count8",     count8,     cnt);
         check_eq("err8",       err8,       err_m);
      end
      if (!rst_i) begin
         pend.delete();
         last_word = '0;
         sent      = 0;
         err_m     = 1'b0;
         model_ok  = 1'b1;
      end else if (model_ok) begin
         rdy = (pend.size() == 0) || out_ready_i;
         hs  = (pend.size() != 0) && out_ready_i;
         acc = in_valid_i && rdy;
         if (hs) begin
            void'(pend.pop_front());
            sent++;
         end
         if (start_i) begin
            sent  = 0;
            err_m = 1'b0;
         end
         if (acc) begin
            if (kind_i >= 4'd8 && CHECK_EN) begin
               err_m = 1'b1;
            end else begin
               w = ref_encode(kind_i, rs_i, rt_i, rd_i, imm_i);
               pend.push_back(w);
               last_word = w;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm);
      in_valid_i = 1'b1;
      kind_i = k; rs_i = rs; rt_i = rt; rd_i = rd; imm_i = imm;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      kind_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; imm_i = '0;
      @(posedge clk);
      #1;
      tick();
      rst_i = 1'b1;

      // Reset state
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_ready", in_ready, 1'b1);
      check_eq("rst_addr8", addr8, 8'hFC);

      // Single R-type add
      set_in(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
      tick();
      in_valid_i = 1'b0;
      check_eq("add_word", instr, 32'h00221820);
      check_eq("add_addr", addr, 32'h0);
      tick();
      check_eq("add_count", count, 16'd1);
      check_eq("wrap_addr8", addr8, 8'h00);

      // Back-to-back addi / ori from a fresh start
      pulse_start();
      set_in(4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF);
      tick();
      check_eq("addi_word", instr, 32'h2022FFFF);
      check_eq("addi_addr", addr, 32'h0);
      set_in(4'd6, 5'd0, 5'd4, 5'd0, 16'h00FF);
      tick();
      in_valid_i = 1'b0;
      check_eq("ori_word", instr, 32'h340400FF);
      check_eq("ori_addr", addr, 32'h4);
      tick();
      check_eq("pair_count", count, 16'd2);

      // beq held under back-pressure; a changed bundle while stalled is ignored
      out_ready_i = 1'b0;
      set_in(4'd7, 5'd1, 5'd2, 5'd0, 16'd3);
      tick();
      set_in(4'd0, 5'd9, 5'd9, 5'd9, 16'h0);
      for (int i = 0; i < 3; i++) begin
         check_eq("beq_hold", instr, 32'h10220003);
         check_eq("beq_ready", in_ready, 1'b0);
         tick();
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      tick();
      check_eq("beq_once", count, 16'd3);
      check_eq("beq_drained", out_valid, 1'b0);

      // start_i coinciding with delivery of the word at address 8
      pulse_start();
      set_in(4'd1, 5'd4, 5'd5, 5'd6, 16'h0);
      repeat (3) tick();
      in_valid_i = 1'b0;
      check_eq("pre_start_addr", addr, 32'h8);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check_eq("post_start_addr", addr, 32'h0);
      set_in(4'd2, 5'd7, 5'd8, 5'd9, 16'h0);
      tick();
      in_valid_i = 1'b0;
      check_eq("next_word_addr", addr, 32'h0);
      tick();
      check_eq("post_start_count", count, 16'd1);

      // Illegal kind
      set_in(4'd9, 5'd3, 5'd3, 5'd3, 16'h1234);
      tick();
      in_valid_i = 1'b0;
      if (CHECK_EN) begin
         check_eq("ill_dropped", out_valid, 1'b0);
         check_eq("ill_err", err, 1'b1);
         repeat (2) tick();
         check_eq("ill_sticky", err, 1'b1);
         pulse_start();
         check_eq("ill_cleared", err, 1'b0);
      end else begin
         check_eq("ill_valid", out_valid, 1'b1);
         check_eq("ill_nop", instr, 32'h0);
         check_eq("ill_err0", err, 1'b0);
         tick();
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_i       = ($urandom_range(0, 199) != 0);
         start_i     = ($urandom_range(0, 19) == 0);
         in_valid_i  = ($urandom_range(0, 9) < 6);
         out_ready_i = ($urandom_range(0, 9) < 7);
         kind_i      = 4'($urandom_range(0, 15));
         rs_i        = 5'($urandom);
         rt_i        = 5'($urandom);
         rd_i        = 5'($urandom);
         imm_i       = 16'($urandom);
         tick();
      end

      // Count saturation: stream continuously past 0xFFFF deliveries
      rst_i = 1'b1;
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      pulse_start();
      for (int i = 0; i < 65540; i++) begin
         set_in(4'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
         tick();
      end
      in_valid_i = 1'b0;
      tick();
      check_eq("count_sat", count, 16'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
